// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcode values, host mnemonic codes and the
// program loader state encoding. The instruction decoder and the loader both
// import this package so the mnemonic-to-opcode mapping has a single source.
package sap1_pkg;

  // Opcode field values as seen by the SAP-1 instruction decoder.
  localparam logic [3:0] OPC_LDA = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_OUT = 4'hE;
  localparam logic [3:0] OPC_HLT = 4'hF;

  // Width of one program word: {opcode, operand}.
  localparam int WORD_W = 8;

  // Word written to every unused address when halt padding is enabled.
  localparam logic [WORD_W-1:0] PAD_WORD = {OPC_HLT, 4'h0};

  // Mnemonic codes on the host stream; codes 5..7 are illegal.
  typedef enum logic [2:0] {
    MN_LDA = 3'd0,
    MN_ADD = 3'd1,
    MN_SUB = 3'd2,
    MN_OUT = 3'd3,
    MN_HLT = 3'd4
  } mnem_e;

  // Loader FSM states. ST_PAD is only reachable when halt padding is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } loader_state_e;

endpackage

// File: rtl/sap1_instr_encoder.sv
// Combinational SAP-1 instruction encoder: mnemonic + operand -> program word.
// OUT and HLT take no operand, so their operand nibble is forced to zero.
// Illegal mnemonics produce a zero word and raise 'illegal'.
module sap1_instr_encoder
  import sap1_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [2:0]       mnem,
  input  logic [3:0]       operand,
  output logic [OPC_W+3:0] word,
  output logic             illegal
);

  logic [OPC_W-1:0] opc;
  logic [3:0]       opnd;

  // Map the mnemonic onto its opcode and mask the operand where unused.
  always_comb begin
    opc     = '0;
    opnd    = operand;
    illegal = 1'b0;
    case (mnem)
      MN_LDA: opc = OPC_W'(OPC_LDA);
      MN_ADD: opc = OPC_W'(OPC_ADD);
      MN_SUB: opc = OPC_W'(OPC_SUB);
      MN_OUT: begin
        opc  = OPC_W'(OPC_OUT);
        opnd = 4'h0;
      end
      MN_HLT: begin
        opc  = OPC_W'(OPC_HLT);
        opnd = 4'h0;
      end
      default: begin
        illegal = 1'b1;
        opnd    = 4'h0;
      end
    endcase
  end

  assign word = {opc, opnd};

endmodule

// File: rtl/sap1_program_loader.sv
// SAP-1 program loader: accepts symbolic instructions over a valid/ready
// stream, encodes them and writes them sequentially into the 16x8 program RAM,
// then releases the CPU through 'run'.
//
// Handshake: a beat transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready depends only on the loader state (high in
// LOAD), never on in_valid. Each legal beat produces exactly one mem_we pulse
// on the following cycle at the current address.
//
// Build option: define SAP1_LOADER_HALT_PAD_EN to fill every address after the
// last legal word with HLT (0xF0) before releasing the CPU.
module sap1_program_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mnem,
  input  logic [3:0]        in_operand,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              run,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              run_q, run_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic [OPC_W+3:0]  enc_word;
  logic              enc_illegal;

  sap1_instr_encoder #(
    .OPC_W (OPC_W)
  ) u_encoder (
    .mnem    (in_mnem),
    .operand (in_operand),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Next-state, address counter, error flag and write-port values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    run_d       = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (enc_illegal) begin
            // Consumed but not written; the address is not advanced.
            err_d = 1'b1;
            if (in_last) begin
              state_d = ST_DONE;
            end
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q;
            mem_wdata_d = enc_word;
            cnt_d       = cnt_q + 1'b1;
            if (in_last) begin
`ifdef SAP1_LOADER_HALT_PAD_EN
              state_d = (cnt_q == CNT_MAX) ? ST_DONE : ST_PAD;
`else
              state_d = ST_DONE;
`endif
            end else if (cnt_q == CNT_MAX) begin
              // RAM is full and the program has not ended: stop, never wrap.
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
`ifdef SAP1_LOADER_HALT_PAD_EN
      ST_PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q;
        mem_wdata_d = PAD_WORD;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          // Registered one cycle after entering DONE so run never overlaps
          // the final write strobe.
          run_d = !err_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      run_q       <= run_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_PAD);
  assign run       = run_q;
  assign err       = err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Testbench for sap1_program_loader: directed programs with hand-computed RAM
// writes pushed into an expected queue; a monitor pops and compares on every
// mem_we. Build with SAP1_LOADER_HALT_PAD_EN to also expect halt padding.
module tb_sap1_program_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_mnem;
  logic [3:0] in_operand;
  logic       in_last;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       run;
  logic       err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [11:0] exp_q[$];
  int          wr_cycles[$];

  sap1_program_loader #(
    .ADDR_W (4),
    .OPC_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_operand (in_operand),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .run        (run),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_cycles.push_back(cyc);
      chk("run_during_write", {31'd0, run}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%02h, none expected", mem_addr, mem_wdata);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("write_addr_data", {20'd0, mem_addr, mem_wdata}, {20'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One beat; if do_wr, the hand-computed word is expected at address addr.
  task automatic send(input logic [2:0] m, input logic [3:0] op, input logic last,
                      input bit do_wr, input logic [3:0] addr, input logic [7:0] word);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_mnem    = m;
    in_operand = op;
    in_last    = last;
    if (do_wr) exp_q.push_back({addr, word});
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for all expected writes (plus pads) to drain, then check run/busy.
  task automatic expect_finish(input int next_addr, input bit do_pad, input bit exp_run);
    int n;
    n = 0;
`ifdef SAP1_LOADER_HALT_PAD_EN
    if (do_pad) begin
      for (int a = next_addr; a < 16; a++) exp_q.push_back({a[3:0], 8'hF0});
    end
`else
    if (do_pad && next_addr > 16) $display("note: bad next_addr %0d", next_addr);
`endif
    @(negedge clk);
    while ((exp_q.size() != 0 || mem_we) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("writes_drained", exp_q.size(), 0);
    chk("run_after_last_write", {31'd0, run}, {31'd0, exp_run});
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_mnem    = 3'd0;
    in_operand = 4'd0;
    in_last    = 1'b0;
    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("reset_addr_data", {20'd0, mem_addr, mem_wdata}, 32'd0);
    chk("reset_flags", {29'd0, busy, run, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: LDA 9, ADD A, OUT, HLT(last), valid held high.
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wr_cycles.delete();
    send(3'd0, 4'h9, 1'b0, 1, 4'd0, 8'h09);
    send(3'd1, 4'hA, 1'b0, 1, 4'd1, 8'h2A);
    send(3'd3, 4'h0, 1'b0, 1, 4'd2, 8'hE0);
    send(3'd4, 4'h0, 1'b1, 1, 4'd3, 8'hF0);
    expect_finish(4, 1, 1);
    chk("t1_err", {31'd0, err}, 32'd0);
    if (wr_cycles.size() >= 4) chk("t1_back_to_back", wr_cycles[3] - wr_cycles[0], 3);
    else chk("t1_write_count", wr_cycles.size(), 4);

    // Test 2: SUB 5, OUT with operand 7 (masked).
    pulse_start();
    chk("t2_run_dropped", {31'd0, run}, 32'd0);
    send(3'd2, 4'h5, 1'b0, 1, 4'd0, 8'h15);
    send(3'd3, 4'h7, 1'b1, 1, 4'd1, 8'hE0);
    expect_finish(2, 1, 1);

    // Test 3: illegal mnemonic between two legal words.
    pulse_start();
    send(3'd0, 4'h3, 1'b0, 1, 4'd0, 8'h03);
    send(3'd6, 4'h5, 1'b0, 0, 4'd0, 8'h00);
    send(3'd3, 4'h1, 1'b1, 1, 4'd1, 8'hE0);
    expect_finish(2, 1, 0);
    chk("t3_err", {31'd0, err}, 32'd1);

    // Test 4: 17-beat stream without in_last overflows after address 15.
    pulse_start();
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = i[3:0];
      send(3'd1, a, 1'b0, 1, a, {4'h2, a});
    end
    expect_finish(16, 0, 0);
    chk("t4_err", {31'd0, err}, 32'd1);
    in_valid = 1'b1;
    in_mnem  = 3'd0;
    repeat (4) @(negedge clk);
    chk("t4_17th_not_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Test 5: reset asserted after the 2nd accept aborts the load.
    pulse_start();
    send(3'd0, 4'h1, 1'b0, 1, 4'd0, 8'h01);
    send(3'd0, 4'h2, 1'b0, 1, 4'd1, 8'h02);
    in_valid = 1'b1;
    in_mnem  = 3'd0;
    in_operand = 4'h3;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t5_async_addr_data", {20'd0, mem_addr, mem_wdata}, 32'd0);
    chk("t5_async_flags", {28'd0, in_ready, busy, run, err}, 32'd0);
    chk("t5_pending_writes", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_not_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    pulse_start();
    send(3'd0, 4'h7, 1'b0, 1, 4'd0, 8'h07);
    send(3'd4, 4'hC, 1'b1, 1, 4'd1, 8'hF0);
    expect_finish(2, 1, 1);

`ifdef SAP1_LOADER_HALT_PAD_EN
    // Test 6: 3-word program, pads 0xF0 at addresses 3..15.
    pulse_start();
    wr_cycles.delete();
    send(3'd0, 4'hE, 1'b0, 1, 4'd0, 8'h0E);
    send(3'd1, 4'hF, 1'b0, 1, 4'd1, 8'h2F);
    send(3'd4, 4'h0, 1'b1, 1, 4'd2, 8'hF0);
    expect_finish(3, 1, 1);
    chk("t6_write_count", wr_cycles.size(), 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap1_program_loader.md
Name: sap1_program_loader

Overview:
Producer end of the SAP-1 opcode interface. It accepts symbolic instructions (mnemonic plus 4-bit operand) over a valid/ready stream and encodes each one into the 8-bit SAP-1 word {opcode[3:0], operand[3:0]}. It writes the words sequentially into the 16x8 program RAM through a write port. When loading completes it releases the CPU through `run`. It sits between the host/test interface and program RAM, ahead of fetch and instruction decode.

Parameters:
- ADDR_W, 4, program RAM address width; depth = 2**ADDR_W (fixed 16 for SAP-1).
- OPC_W, 4, opcode field width; the word is {opcode, operand} with an 8-bit total.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a load from address 0 (honoured only in IDLE or DONE)
- in_valid  in  1  instruction available
- in_ready  out  1  loader can accept
- in_mnem  in  3  0=LDA, 1=ADD, 2=SUB, 3=OUT, 4=HLT, 5..7 illegal
- in_operand  in  4  address operand
- in_last  in  1  final instruction of the program
- mem_we  out  1  RAM write strobe, one cycle per word
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  8  encoded instruction word
- busy  out  1  high in LOAD or PAD
- run  out  1  CPU release; high in DONE when err=0
- err  out  1  sticky; illegal mnemonic or overflow

Behaviour:
- Reset (async): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, run=0, err=0, address counter=0.
- Encoding, fixed and matching the decoder: LDA→0x0, SUB→0x1, ADD→0x2, OUT→0xE, HLT→0xF.
- The operand field is forced to 0 for OUT and HLT.
- States:
  - IDLE: in_ready=0. On start → LOAD, counter=0, err=0.
  - LOAD: in_ready=1. A word is accepted when in_valid&in_ready. The accept registers mem_we=1, mem_addr=counter, mem_wdata=encoded word on the following cycle (1-cycle latency). The counter then increments.
  - PAD: described under Optional Feature.
  - DONE: in_ready=0, busy=0, run=!err. On start → LOAD (counter=0, err cleared, run drops the next cycle).
- Illegal mnemonic (5..7): the word is consumed (ready stays high) but not written, and the counter is held. err is set. If in_last is set on that beat, loading still terminates.
- Accepting in_last with a legal mnemonic: the word is written, then → DONE (or PAD).
- Overflow: accepting the word at address 15 without in_last writes it, sets err, and → DONE. No wrap-around write to address 0 ever occurs.
- run rises the cycle after the final mem_we. It never overlaps a mem_we.
- start while busy is ignored.
- rst_n asserted mid-load aborts immediately. No further writes occur; RAM contents are undefined to the loader.
- mem_we is strictly a 1-cycle pulse per word. Back-to-back accepts produce back-to-back writes at consecutive addresses.

Optional Feature:
- Macro: SAP1_LOADER_HALT_PAD_EN.
- Defined: after the last legal word (and not on overflow), enter PAD with in_ready=0. PAD writes 0xF0 (HLT) to every remaining address through 15, one per cycle, then → DONE. run rises the cycle after the address-15 pad write.
- Undefined: the PAD state does not exist and loading goes straight to DONE. Unwritten addresses retain prior contents.

Decomposition:
- Shared package sap1_pkg: opcode localparams (OPC_LDA=4'h0, OPC_SUB=4'h1, OPC_ADD=4'h2, OPC_OUT=4'hE, OPC_HLT=4'hF), mnemonic enum codes, loader state encoding. The decoder and loader both use these so the mapping cannot diverge.
- One sub-module, sap1_instr_encoder: combinational mnemonic+operand → {word, illegal}. The FSM, counter and handshake stay in sap1_program_loader.

Test Plan:
- Load LDA 9, ADD A, OUT, HLT (last) with in_valid held high → writes 0x09@0, 0x2A@1, 0xE0@2, 0xF0@3 on consecutive cycles; run=1 the next cycle; err=0.
- SUB 5 with operand on OUT set to 7 → 0x15 written, and the OUT word is 0xE0 (operand masked).
- Illegal mnemonic 6 between two legal words → err=1, the two legal words land at addresses 0 and 1, run=0 in DONE.
- Seventeen-beat stream with in_last never set → 16 writes (0..15), err=1, 17th beat not accepted (in_ready=0), no write to address 0 after address 15.
- rst_n pulsed low after the 2nd accept → all outputs return to reset values asynchronously; no further mem_we; start restarts from address 0.
- With SAP1_LOADER_HALT_PAD_EN: a 3-word program → 13 pad writes of 0xF0 at addresses 3..15; run rises the cycle after the address-15 write.
